ntru_mac_pipe: RTL
==================

Name: ntru_mac_pipe

Overview:
- Pipelined, parametrised signed multiply(-accumulate) unit for NTRU polynomial arithmetic (ntru-hps2048677 keypair/encaps datapaths).
- Successor to the single-cycle 16x16->16 truncating multiplier.
- Adds:
  - configurable pipeline depth and operand/result widths;
  - valid/ready handshaking with backpressure;
  - a per-item accumulate mode for coefficient dot products.
- Sits between the coefficient fetch logic and the polynomial result buffer.

Parameters:
- DIN0_WIDTH, 16, signed width of operand din0 (>=2)
- DIN1_WIDTH, 16, signed width of operand din1 (>=2)
- DOUT_WIDTH, 16, result width; results wrap modulo 2^DOUT_WIDTH
- NUM_STAGE, 3, total latency in cycles from accept to out_valid (>=2)
- LOGQ, 11, log2 of NTRU modulus q; used only under the optional feature (LOGQ <= DOUT_WIDTH)

Ports:
- ap_clk  in  1  clock, all state on rising edge
- ap_rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input item present
- in_ready  out  1  unit can accept an item this cycle
- din0  in  DIN0_WIDTH  signed operand a
- din1  in  DIN1_WIDTH  signed operand b
- acc  in  1  1 = add product to previous result; 0 = start new sum
- out_valid  out  1  dout holds a result
- out_ready  in  1  consumer accepts dout this cycle
- dout  out  DOUT_WIDTH  result
- busy  out  1  any pipeline stage holds a valid item

Behaviour:
- Reset (async, asserted ap_rst_n=0): all stage valid bits, out_valid, dout and busy go to 0 immediately. in_ready=1 from the first cycle after release.
- Global enable:
  - ce = !out_valid || out_ready.
  - in_ready = ce (combinational).
  - All stages shift only when ce=1. Bubbles are not squeezed out.
- Accept: in_valid && in_ready at edge k. Stage 1 registers din0, din1, acc and valid=1.
- Latency: with no stall, the accepted item's result appears with out_valid=1 after edge k+NUM_STAGE-1, i.e. NUM_STAGE cycles including the accept cycle.
- Throughput: one item per cycle while out_ready=1.
- Arithmetic:
  - prod = signed(din0)*signed(din1), full DIN0_WIDTH+DIN1_WIDTH bits internally.
  - Then truncated to the low DOUT_WIDTH bits (two's-complement wrap).
  - Multiply is computed in the stage-1 to stage-2 path; the middle stages are delay registers.
- Final stage, on load of a valid item:
  - acc=0: dout <= prod_trunc.
  - acc=1: dout <= (dout + prod_trunc) mod 2^DOUT_WIDTH, using the value of the previously produced result still in dout.
- acc=1 on the first item after reset adds to 0.
- Bubble reaching the final stage with ce=1: out_valid <= 0, dout holds its value so the accumulation chain survives bubbles.
- Stall (out_valid=1, out_ready=0): every stage, dout and out_valid hold; in_ready=0; inputs are ignored.
- Simultaneous out_ready=1 and in_valid=1 with a full pipeline: output consumed and new item accepted in the same cycle.
- busy = OR of all stage valid bits including out_valid.
- Reset mid-operation discards all in-flight items; no partial output.

Optional Feature:
- NTRU_MAC_MOD_Q_EN defined:
  - The final-stage result is masked to the low LOGQ bits (reduction mod q=2^LOGQ) before being stored to dout.
  - Upper DOUT_WIDTH-LOGQ bits of dout are 0.
  - The accumulate adds to the masked value.
- Not defined: full DOUT_WIDTH wrap only. LOGQ is unused.

Decomposition:
- Package ntru_arith_pkg holds:
  - constants NTRU_N=677, NTRU_LOGQ=11, COEF_W=16;
  - typedef coef_t (signed [COEF_W-1:0]);
  - default stage count.
- One sub-module, ntru_mul_trunc: combinational signed multiply with truncation to DOUT_WIDTH. It is instantiated once between stage 1 and stage 2 and maps to DSP48.

Test Plan (defaults unless stated):
- Reset, then in_valid=1, din0=0x7FFF, din1=2, acc=0 -> out_valid exactly 3 cycles later, dout=0xFFFE; busy=1 for those 3 cycles.
- din0=-3, din1=5, acc=0 -> dout=0xFFF1. With NTRU_MAC_MOD_Q_EN -> dout=0x07F1.
- Items (3,4,acc=0), (5,6,acc=1), (2,2,acc=1), back-to-back -> dout sequence 12, 42, 46 on consecutive cycles. Repeat with a 2-cycle bubble before the third item -> still 46.
- 5 back-to-back items, out_ready=0 for 4 cycles after the first out_valid:
  - dout is held stable;
  - in_ready=0 during the stall;
  - no item is lost or duplicated;
  - all 5 results come out in order.
- Pulse ap_rst_n low while 3 items are in flight (asynchronously, mid-cycle) -> out_valid, busy, dout=0 immediately; no stale result after release.
- NUM_STAGE=2, DIN0/DIN1/DOUT=12 -> latency 2. din0=0x7FF, din1=0x7FF gives dout=0x001 (0x3FF001 truncated to 12 bits).

Source files
------------

// File: rtl/ntru_arith_pkg.sv
// Shared NTRU arithmetic constants and coefficient type.
// Used by the MAC pipeline and its multiplier.
package ntru_arith_pkg;
  localparam int NTRU_N    = 677;
  localparam int NTRU_LOGQ = 11;
  localparam int COEF_W    = 16;
  localparam int MAC_STAGES = 3;

  typedef logic signed [COEF_W-1:0] coef_t;
endpackage

// File: rtl/ntru_mul_trunc.sv
// Combinational signed multiply, result truncated to P_W bits.
// Intended to map onto a single DSP slice.
module ntru_mul_trunc
  import ntru_arith_pkg::*;
#(
  parameter int A_W = COEF_W,
  parameter int B_W = COEF_W,
  parameter int P_W = COEF_W
) (
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  output logic        [P_W-1:0] p
);
  localparam int FW = A_W + B_W;

  logic signed [FW-1:0] ax;
  logic signed [FW-1:0] bx;

  assign ax = FW'(a);
  assign bx = FW'(b);
  assign p  = P_W'(ax * bx);
endmodule

// File: rtl/ntru_mac_pipe.sv
// Pipelined signed multiply-accumulate with valid/ready backpressure.
// Optional NTRU_MAC_MOD_Q_EN masks results to the low LOGQ bits.
module ntru_mac_pipe
  import ntru_arith_pkg::*;
#(
  parameter int DIN0_WIDTH = COEF_W,
  parameter int DIN1_WIDTH = COEF_W,
  parameter int DOUT_WIDTH = COEF_W,
  parameter int NUM_STAGE  = MAC_STAGES,
  parameter int LOGQ       = NTRU_LOGQ
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  acc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  busy
);
  localparam int MID = NUM_STAGE - 2;
`ifdef NTRU_MAC_MOD_Q_EN
  localparam int QCUT = DOUT_WIDTH - LOGQ;
`else
  localparam int QCUT = 0 * LOGQ;
`endif
  localparam logic [DOUT_WIDTH-1:0] KEEP =
    {DOUT_WIDTH{1'b1}} >> QCUT;

  logic                         ce;
  logic signed [DIN0_WIDTH-1:0] s1_a;
  logic signed [DIN1_WIDTH-1:0] s1_b;
  logic                         s1_acc;
  logic                         s1_v;
  logic [DOUT_WIDTH-1:0]        prod;
  logic [DOUT_WIDTH-1:0]        tail_p;
  logic                         tail_acc;
  logic                         tail_v;
  logic                         mid_busy;
  logic [DOUT_WIDTH-1:0]        sum;

  assign ce       = !out_valid || out_ready;
  assign in_ready = ce;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_v <= 1'b0;
    end else if (ce) begin
      s1_v <= in_valid;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ce) begin
      s1_a   <= din0;
      s1_b   <= din1;
      s1_acc <= acc;
    end
  end

  ntru_mul_trunc #(
    .A_W(DIN0_WIDTH),
    .B_W(DIN1_WIDTH),
    .P_W(DOUT_WIDTH)
  ) u_mul (
    .a(s1_a),
    .b(s1_b),
    .p(prod)
  );

  if (MID == 0) begin : g_direct
    assign tail_p   = prod;
    assign tail_acc = s1_acc;
    assign tail_v   = s1_v;
    assign mid_busy = 1'b0;
  end else begin : g_delay
    logic [DOUT_WIDTH-1:0] p_q [MID];
    logic [MID-1:0]        acc_q;
    logic [MID-1:0]        v_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        v_q <= '0;
      end else if (ce) begin
        v_q[0] <= s1_v;
        for (int i = 1; i < MID; i++) begin
          v_q[i] <= v_q[i-1];
        end
      end
    end

    always_ff @(posedge ap_clk) begin
      if (ce) begin
        p_q[0]   <= prod;
        acc_q[0] <= s1_acc;
        for (int i = 1; i < MID; i++) begin
          p_q[i]   <= p_q[i-1];
          acc_q[i] <= acc_q[i-1];
        end
      end
    end

    assign tail_p   = p_q[MID-1];
    assign tail_acc = acc_q[MID-1];
    assign tail_v   = v_q[MID-1];
    assign mid_busy = |v_q;
  end

  assign sum = ((tail_acc ? dout : '0) + tail_p) & KEEP;

  // dout only changes on a valid item so bubbles keep the running sum
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
    end else if (ce) begin
      out_valid <= tail_v;
      if (tail_v) begin
        dout <= sum;
      end
    end
  end

  assign busy = s1_v | mid_busy | out_valid;
endmodule
